// File: rtl/l2_req_credit_arb.sv
// Round-robin host request scheduler with global and per-channel outstanding credit limits.
// Optional credit-stall cycle counter is built when L2_REQ_STALL_CNT_EN is defined.

module l2_req_chan_cnt #(
    parameter int cnt_width    = 6,
    parameter int chan_max_out = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic inc,
    input  logic dec,
    output logic has_credit,
    output logic udf
);
    localparam logic [cnt_width-1:0] lim = cnt_width'(chan_max_out);

    logic [cnt_width-1:0] cnt;
    logic                 dec_ok;

    assign has_credit = cnt < lim;
    assign udf        = dec && (cnt == '0);
    assign dec_ok     = dec && (cnt != '0);

    // Grant and response on the same edge cancel; an underflowing return saturates at 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            cnt <= '0;
        else if (inc && !dec_ok)
            cnt <= cnt + 1'b1;
        else if (!inc && dec_ok)
            cnt <= cnt - 1'b1;
    end
endmodule

module l2_req_credit_arb #(
    parameter int addr_width      = 64,
    parameter int nstrms          = 64,
    parameter int l2_nstrms       = 16,
    parameter int l2_nstrms_width = $clog2(l2_nstrms),
    parameter int nstrms_width    = $clog2(nstrms),
    parameter int channels        = nstrms / l2_nstrms,
    parameter int max_out         = 32,
    parameter int chan_max_out    = 16,
    parameter int cnt_width       = $clog2(max_out + 1)
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic [channels-1:0]                  i_req_v,
    output logic [channels-1:0]                  i_req_r,
    input  logic [channels*addr_width-1:0]       i_req_ea,
    input  logic [channels*l2_nstrms_width-1:0]  i_req_sid,
    output logic                                 o_req_v,
    input  logic                                 o_req_r,
    output logic [nstrms_width-1:0]              o_req_sid,
    output logic [addr_width-1:0]                o_req_ea,
    input  logic                                 i_rsp_v,
    output logic                                 i_rsp_r,
    input  logic [nstrms_width-1:0]              i_rsp_sid,
    output logic                                 o_rsp_v,
    input  logic                                 o_rsp_r,
    output logic [nstrms_width-1:0]              o_rsp_sid,
    output logic [cnt_width-1:0]                 o_credits,
    output logic                                 o_err,
    output logic [31:0]                          o_stall_cnt
);
    localparam int                   ch_width = $clog2(channels);
    localparam logic [cnt_width-1:0] gmax     = cnt_width'(max_out);

    logic [channels-1:0][addr_width-1:0]      req_ea;
    logic [channels-1:0][l2_nstrms_width-1:0] req_sid;
    logic [channels-1:0]                      chan_credit, elig, rsp_dec, udf_chan, grant_vec;
    logic [cnt_width-1:0]                     gcnt;
    logic [ch_width-1:0]                      rr_ptr, gidx, idx, rsp_ch;
    logic                                     found, slot_free, grant, rsp_fire, g_dec_ok, g_udf;

    assign req_ea  = i_req_ea;
    assign req_sid = i_req_sid;

    // Response path is a pure pass-through; credit return rides on its handshake.
    assign i_rsp_r   = o_rsp_r;
    assign o_rsp_v   = i_rsp_v;
    assign o_rsp_sid = i_rsp_sid;
    assign rsp_fire  = i_rsp_v && o_rsp_r;
    assign rsp_ch    = i_rsp_sid[nstrms_width-1:l2_nstrms_width];

    assign slot_free = !o_req_v || o_req_r;
    assign g_udf     = rsp_fire && (gcnt == '0);
    assign g_dec_ok  = rsp_fire && (gcnt != '0);
    assign o_credits = gmax - gcnt;

    always_comb begin
        found = 1'b0;
        gidx  = '0;
        idx   = '0;
        for (int i = 0; i < channels; i++) begin
            idx = rr_ptr + ch_width'(i);
            if (!found && elig[idx]) begin
                found = 1'b1;
                gidx  = idx;
            end
        end
    end

    // Reset gating keeps ready low while reset is held.
    assign grant   = slot_free && found && !reset;
    assign i_req_r = grant_vec;

    for (genvar c = 0; c < channels; c++) begin : g_chan
        assign grant_vec[c] = grant && (gidx == ch_width'(c));
        assign rsp_dec[c]   = rsp_fire && (rsp_ch == ch_width'(c));
        assign elig[c]      = i_req_v[c] && chan_credit[c] && (gcnt < gmax);

        l2_req_chan_cnt #(
            .cnt_width    (cnt_width),
            .chan_max_out (chan_max_out)
        ) u_cnt (
            .clk        (clk),
            .reset      (reset),
            .inc        (grant_vec[c]),
            .dec        (rsp_dec[c]),
            .has_credit (chan_credit[c]),
            .udf        (udf_chan[c])
        );
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            gcnt <= '0;
        else if (grant && !g_dec_ok)
            gcnt <= gcnt + 1'b1;
        else if (!grant && g_dec_ok)
            gcnt <= gcnt - 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            o_err <= 1'b0;
        else if (g_udf || |udf_chan)
            o_err <= 1'b1;
    end

    // Credits are charged at grant, so a request parked here is already outstanding.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            o_req_v   <= 1'b0;
            o_req_sid <= '0;
            o_req_ea  <= '0;
            rr_ptr    <= '0;
        end else if (grant) begin
            o_req_v   <= 1'b1;
            o_req_sid <= {gidx, req_sid[gidx]};
            o_req_ea  <= req_ea[gidx];
            rr_ptr    <= gidx + 1'b1;
        end else if (slot_free) begin
            o_req_v   <= 1'b0;
        end
    end

`ifdef L2_REQ_STALL_CNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            o_stall_cnt <= '0;
        else if (slot_free && |i_req_v && !(|elig))
            o_stall_cnt <= o_stall_cnt + 32'd1;
    end
`else
    assign o_stall_cnt = '0;
`endif
endmodule
